// File: rtl/satalnk_txctrl.sv
// rtl/satalnk_txctrl.sv - SATA link-layer TX sequencer (optional watchdog: SATALNK_TXCTRL_WATCHDOG_EN)
module satalnk_txctrl #(
  parameter int          LGTIMEOUT = 20,
  parameter logic [32:0] P_SYNC    = 33'h1_7c95_b5b5,
  parameter logic [32:0] P_XRDY    = 33'h1_7cb5_5757,
  parameter logic [32:0] P_RRDY    = 33'h1_7cb5_4a4a,
  parameter logic [32:0] P_ROK     = 33'h1_7cb5_3535,
  parameter logic [32:0] P_RERR    = 33'h1_7cb5_5656,
  parameter logic [32:0] P_WTRM    = 33'h1_7cb5_5858,
  parameter logic [32:0] P_HOLD    = 33'h1_7caa_d5d5,
  parameter logic [32:0] P_HOLDA   = 33'h1_7caa_9595
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  input  logic [31:0] s_data,
  output logic        f_valid,
  input  logic        f_ready,
  output logic        f_last,
  output logic [31:0] f_data,
  input  logic        p_valid,
  output logic        p_ready,
  input  logic        p_primitive,
  input  logic        p_last,
  input  logic [31:0] p_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_primitive,
  output logic [31:0] m_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_primitive,
  input  logic [31:0] i_rx_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_XRDY, ST_DATA, ST_WAIT, ST_DONE, ST_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic        hold_q, hold_d;
  logic        m_valid_q;
  logic [32:0] m_word_q, word_d;
  logic        busy_q, done_q, err_q;
  logic        wd_expired;

  logic rx_prim, rx_sync, rx_rrdy, rx_rok, rx_rerr, rx_hold;
  logic load, p_take;

  assign rx_prim = i_rx_valid && i_rx_primitive;
  assign rx_sync = rx_prim && (i_rx_data == P_SYNC[31:0]);
  assign rx_rrdy = rx_prim && (i_rx_data == P_RRDY[31:0]);
  assign rx_rok  = rx_prim && (i_rx_data == P_ROK[31:0]);
  assign rx_rerr = rx_prim && (i_rx_data == P_RERR[31:0]);
  assign rx_hold = rx_prim && (i_rx_data == P_HOLD[31:0]);

  // The output register can take a new word whenever it is empty or being drained.
  assign load    = !m_valid_q || m_ready;
  assign p_ready = (state_q == ST_DATA) && !hold_q && load;
  assign p_take  = p_valid && p_ready;

  // The frame source is only connected to the pipeline while a frame is being sent.
  assign f_valid = s_valid && (state_q == ST_DATA);
  assign s_ready = f_ready && (state_q == ST_DATA);
  assign f_last  = s_last;
  assign f_data  = s_data;

  assign m_valid     = m_valid_q;
  assign m_primitive = m_word_q[32];
  assign m_data      = m_word_q[31:0];
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

`ifdef SATALNK_TXCTRL_WATCHDOG_EN
  logic [LGTIMEOUT-1:0] wd_q, wd_d;

  assign wd_expired = &wd_q;

  // Watchdog counts time spent waiting on the device and restarts on every state change.
  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q) begin
      wd_d = '0;
    end else if (state_q == ST_XRDY || state_q == ST_WAIT) begin
      wd_d = wd_q + LGTIMEOUT'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_lgtimeout;
  assign wd_expired       = 1'b0;
  assign unused_lgtimeout = (LGTIMEOUT != 0);
`endif

  // HOLD from the device stalls the pipeline until any other primitive arrives.
  always_comb begin
    hold_d = hold_q;
    if (rx_prim) begin
      hold_d = rx_hold;
    end
  end

  // Sequencer: next state and the word to place on the PHY stream.
  always_comb begin
    state_d = state_q;
    word_d  = P_SYNC;
    case (state_q)
      ST_IDLE: begin
        word_d = P_SYNC;
        if (s_valid) state_d = ST_XRDY;
      end
      ST_XRDY: begin
        word_d = P_XRDY;
        if (rx_sync || wd_expired) state_d = ST_FAIL;
        else if (rx_rrdy)          state_d = ST_DATA;
      end
      ST_DATA: begin
        if (p_take)      word_d = {p_primitive, p_data};
        else if (hold_q) word_d = P_HOLDA;
        else             word_d = P_HOLD;
        // A SYNC abort wins over an EOF leaving in the same cycle.
        if (rx_sync)              state_d = ST_FAIL;
        else if (p_take && p_last) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        word_d = P_WTRM;
        if (rx_sync || rx_rerr || wd_expired) state_d = ST_FAIL;
        else if (rx_rok)                      state_d = ST_DONE;
      end
      ST_DONE, ST_FAIL: begin
        word_d  = P_SYNC;
        state_d = ST_IDLE;
      end
      default: begin
        word_d  = P_SYNC;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, hold flag, PHY output register and status flags.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= ST_IDLE;
      hold_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_word_q  <= P_SYNC;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      m_valid_q <= 1'b1;
      if (load) m_word_q <= word_d;
      busy_q    <= (state_d == ST_XRDY) || (state_d == ST_DATA) || (state_d == ST_WAIT);
      done_q    <= (state_d == ST_DONE) || (state_d == ST_FAIL);
      err_q     <= (state_d == ST_FAIL);
    end
  end

endmodule
